mem_sequencer: RTL

- Controller for the Chip-8 main-memory manager.
- Arbitrates three requesters that share the single address_counter/address/write path:
  - opcode fetch at PC
  - register store, the FX55 burst write
  - burst read, used by FX65 and DXYN sprite fetch
- Sequences the counter so each burst lands byte-for-byte in the manager's 16-byte read/write buffers.
- Sits between the CPU control FSM and the memory manager.

---
 rtl/mem_sequencer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mem_sequencer.sv
// Chip-8 memory-manager sequencer: arbitrates opcode fetch, burst read and burst write
// onto the shared address/counter/write path. Optional bounds check: MEMSEQ_BOUNDS_CHECK_EN.
module mem_sequencer #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic              read_req,
  input  logic              write_req,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [3:0]        req_count,
  output logic              busy,
  output logic              done,
  output logic              opcode_valid,
  output logic              err,
  output logic              mm_write_enable,
  output logic [3:0]        mm_write_count,
  output logic [ADDR_W-1:0] mm_address,
  output logic [CNT_W-1:0]  mm_address_counter
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    READ   = 3'd2,
    WRITE  = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          wcnt_q, wcnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                ov_q, ov_d;
  logic                err_q, err_d;
  logic                we_q, we_d;
  logic [4:0]          last_s;
  logic                burst_oob_s;
  logic                fetch_oob_s;

`ifdef MEMSEQ_BOUNDS_CHECK_EN
  logic [ADDR_W:0]     burst_end_s;
  assign burst_end_s = {1'b0, req_addr} + (ADDR_W+1)'(req_count);
  assign burst_oob_s = burst_end_s[ADDR_W];
  assign fetch_oob_s = &req_addr;
`else
  assign burst_oob_s = 1'b0;
  assign fetch_oob_s = 1'b0;
`endif

  // Burst bursts end when the counter reaches N+1 (one extra cycle for the manager's read pipeline).
  assign last_s = 5'(wcnt_q) + 5'd1;

  // Next-state and next-output logic; outputs are registered from these values.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ov_d    = 1'b0;
    err_d   = 1'b0;
    we_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = CNT_W'(0);
        if (write_req) begin
          if (burst_oob_s) begin
            err_d = 1'b1;
          end else begin
            state_d = WRITE;
            addr_d  = req_addr;
            wcnt_d  = req_count;
            busy_d  = 1'b1;
            we_d    = 1'b1;
          end
        end else if (read_req) begin
          if (burst_oob_s) begin
            err_d = 1'b1;
          end else begin
            state_d = READ;
            addr_d  = req_addr;
            wcnt_d  = req_count;
            busy_d  = 1'b1;
          end
        end else if (fetch_req) begin
          if (fetch_oob_s) begin
            err_d = 1'b1;
          end else begin
            state_d = FETCH;
            addr_d  = req_addr;
            wcnt_d  = req_count;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      FETCH: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = FINISH;
          cnt_d   = CNT_W'(0);
          ov_d    = 1'b1;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          busy_d = 1'b1;
        end
      end
      READ, WRITE: begin
        if (cnt_q == CNT_W'(last_s)) begin
          state_d = FINISH;
          cnt_d   = CNT_W'(0);
          done_d  = 1'b1;
        end else begin
          cnt_d  = cnt_q + CNT_W'(1);
          busy_d = 1'b1;
          we_d   = (state_q == WRITE);
        end
      end
      FINISH: begin
        state_d = IDLE;
        cnt_d   = CNT_W'(0);
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_W'(0);
      end
    endcase
  end

  // State and output registers; reset abandons any burst immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= CNT_W'(0);
      addr_q  <= ADDR_W'(0);
      wcnt_q  <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ov_q    <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ov_q    <= ov_d;
      err_q   <= err_d;
      we_q    <= we_d;
    end
  end

  assign busy               = busy_q;
  assign done               = done_q;
  assign opcode_valid       = ov_q;
  assign err                = err_q;
  assign mm_write_enable    = we_q;
  assign mm_write_count     = wcnt_q;
  assign mm_address         = addr_q;
  assign mm_address_counter = cnt_q;

endmodule
